// File: rtl/tc_sram_stream_adapter_pkg.sv
// Parameter helpers for the tc_sram stream adapter, matching how tc_sram
// derives its address and byte-enable widths.
package tc_sram_stream_adapter_pkg;

   function automatic int unsigned addr_bits(input int unsigned num_words);
      return (num_words > 1) ? $clog2(num_words) : 1;
   endfunction

   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/tc_sram_rsp_fifo.sv
// Fall-through response FIFO: an arriving word is visible on data_o in the
// same cycle when the FIFO is empty, and is stored only if not popped.
module tc_sram_rsp_fifo #(
   parameter int unsigned Depth = 1,
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntWidth = $clog2(Depth + 1);

   logic [Width-1:0]    mem_q [Depth];
   logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntWidth-1:0] cnt_q;
   logic                bypass, do_write, do_read;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
      return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntWidth'(Depth));

   // A push popped straight off an empty FIFO never touches storage.
   assign bypass   = empty_o & push_i & pop_i;
   assign do_write = push_i & !bypass;
   assign do_read  = pop_i & !empty_o;

   assign data_o = !empty_o ? mem_q[rd_ptr_q] : (push_i ? data_i : '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_write) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_read)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_write, do_read})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_write) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/tc_sram_stream_adapter.sv
// Valid/ready front end for the single-port tc_sram macro: fixed-latency read
// data is caught in a fall-through FIFO, with credits bounding reads in flight.
module tc_sram_stream_adapter
   import tc_sram_stream_adapter_pkg::*;
#(
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   parameter int unsigned RspDepth  = Latency,
   parameter int unsigned AddrWidth = addr_bits(NumWords),
   parameter int unsigned BeWidth   = ceil_div(DataWidth, ByteWidth)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   input  logic [BeWidth-1:0]   req_be_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);

   typedef logic [AddrWidth-1:0] addr_t;
   typedef logic [DataWidth-1:0] data_t;
   typedef logic [BeWidth-1:0]   be_t;

   localparam int unsigned CreditWidth = $clog2(RspDepth + 1);
   localparam logic [CreditWidth-1:0] CreditMax = CreditWidth'(RspDepth);

   logic [CreditWidth-1:0] credit_q, credit_d;
   logic [Latency-1:0]     inflight_q;
   logic                   read_grant, rd_issue, rsp_pop, rsp_push;
   logic                   fifo_full, fifo_empty;
   data_t                  fifo_rdata;

   // Handshake: a request transfers on a cycle with valid & ready both high;
   // a response transfers on a cycle with rsp_valid & rsp_ready both high.
   // A pop in the same cycle frees its credit for a read offered alongside it.
   assign read_grant  = (credit_q < CreditMax) | rsp_pop;
   assign req_ready_o = !rst_i & (req_we_i | read_grant);
   assign sram_req_o  = req_valid_i & req_ready_o;
   assign rd_issue    = sram_req_o & !req_we_i;

   assign sram_we_o    = req_we_i;
   assign sram_addr_o  = addr_t'(req_addr_i);
   assign sram_wdata_o = data_t'(req_wdata_i);
   assign sram_be_o    = be_t'(req_be_i);

   // The flag leaving the tracker marks sram_rdata_i as a live read result.
   assign rsp_push    = inflight_q[Latency-1] & !rst_i;
   assign rsp_valid_o = !rst_i & (!fifo_empty | rsp_push);
   assign rsp_rdata_o = rst_i ? '0 : fifo_rdata;
   assign rsp_pop     = rsp_valid_o & rsp_ready_i;

   always_comb begin
      credit_d = credit_q;
      case ({rd_issue, rsp_pop})
         2'b10:   credit_d = credit_q + 1'b1;
         2'b01:   credit_d = credit_q - 1'b1;
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         credit_q   <= '0;
         inflight_q <= '0;
      end else begin
         credit_q   <= credit_d;
         inflight_q <= (inflight_q << 1) | Latency'(rd_issue);
      end
   end

   tc_sram_rsp_fifo #(
      .Depth (RspDepth),
      .Width (DataWidth)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (rsp_push),
      .data_i  (sram_rdata_i),
      .pop_i   (rsp_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Credits account for every FIFO slot, so a push can never meet a full FIFO.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(rsp_push && fifo_full));
         assert (credit_q <= CreditMax);
      end
   end

endmodule

// File: tb/tb_tc_sram_stream_adapter.sv
// Directed and random checks of tc_sram_stream_adapter against a
// behavioural tc_sram model with Latency=2, RspDepth=2.
module tb_tc_sram_stream_adapter;

   localparam int unsigned NumWords  = 1024;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned Latency   = 2;
   localparam int unsigned RspDepth  = 2;

   logic        clk_i;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [9:0]  req_addr_i;
   logic [31:0] req_wdata_i;
   logic [3:0]  req_be_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        sram_req_o;
   logic        sram_we_o;
   logic [9:0]  sram_addr_o;
   logic [31:0] sram_wdata_o;
   logic [3:0]  sram_be_o;
   logic [31:0] sram_rdata_i;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];

   tc_sram_stream_adapter #(
      .NumWords  (NumWords),
      .DataWidth (DataWidth),
      .ByteWidth (8),
      .Latency   (Latency),
      .RspDepth  (RspDepth)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_we_i     (req_we_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .req_be_i     (req_be_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .sram_req_o   (sram_req_o),
      .sram_we_o    (sram_we_o),
      .sram_addr_o  (sram_addr_o),
      .sram_wdata_o (sram_wdata_o),
      .sram_be_o    (sram_be_o),
      .sram_rdata_i (sram_rdata_i)
   );

   // clock / reset
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // behavioural tc_sram, two-cycle read latency
   logic [31:0] sram_mem [NumWords];
   logic [31:0] rd_s1, rd_s2;

   initial begin
      for (int i = 0; i < int'(NumWords); i++) sram_mem[i] = '0;
      rd_s1 = '0;
      rd_s2 = '0;
   end

   always @(posedge clk_i) begin
      if (sram_req_o) begin
         if (sram_we_o) begin
            for (int b = 0; b < 4; b++)
               if (sram_be_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
         end else begin
            rd_s1 <= sram_mem[sram_addr_o];
         end
      end
      rd_s2 <= rd_s1;
   end
   assign sram_rdata_i = rd_s2;

   // driver tasks
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      req_valid_i = v;
      req_we_i    = we;
      req_addr_i  = a;
      req_wdata_i = d;
      req_be_i    = be;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, '0);
   endtask

   // scenarios
   task automatic test_reset();
      rst_i = 1'b1;
      rsp_ready_i = 1'b1;
      drive(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
      tick();
      tick();
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready_rd: got %b want 0", req_ready_o); end
      checks++;
      if (sram_req_o !== 1'b0) begin failures++; $display("FAIL reset_sram_req: got %b want 0", sram_req_o); end
      checks++;
      if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
      checks++;
      if (rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata_o); end
      tick();
      drive(1'b1, 1'b1, 10'h010, 32'h1234_5678, 4'hF);
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready_wr: got %b want 0", req_ready_o); end
      tick();
      rst_i = 1'b0;
      idle();
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b want 1", req_ready_o); end
      checks++;
      if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL post_reset_rsp_valid: got %b want 0", rsp_valid_o); end
      tick();
   endtask

   task automatic test_write_read();
      rsp_ready_i = 1'b0;
      drive(1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF);
      @(negedge clk_i);
      checks++;
      if ({req_ready_o, sram_req_o, sram_we_o} !== 3'b111) begin
         failures++; $display("FAIL wr_handshake: got %b want 111", {req_ready_o, sram_req_o, sram_we_o});
      end
      checks++;
      if (sram_addr_o !== 10'h010 || sram_wdata_o !== 32'hDEAD_BEEF || sram_be_o !== 4'hF) begin
         failures++; $display("FAIL wr_passthru: got %h/%h/%h want 010/deadbeef/f", sram_addr_o, sram_wdata_o, sram_be_o);
      end
      tick();
      drive(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
      @(negedge clk_i);
      checks++;
      if ({req_ready_o, sram_req_o, sram_we_o} !== 3'b110) begin
         failures++; $display("FAIL rd_handshake: got %b want 110", {req_ready_o, sram_req_o, sram_we_o});
      end
      tick();
      idle();
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL wr_rd_early: got %b want 0", rsp_valid_o); end
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL wr_rd_data: got v=%b d=%h want v=1 d=deadbeef", rsp_valid_o, rsp_rdata_o);
      end
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL wr_rd_after: got %b want 0", rsp_valid_o); end
      tick();
   endtask

   task automatic test_partial_write();
      drive(1'b1, 1'b1, 10'h020, 32'h1122_3344, 4'hF);
      tick();
      drive(1'b1, 1'b1, 10'h020, 32'hAABB_CCDD, 4'h5);
      tick();
      drive(1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
      tick();
      idle();
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h11BB_33DD) begin
         failures++; $display("FAIL partial_write: got v=%b d=%h want v=1 d=11bb33dd", rsp_valid_o, rsp_rdata_o);
      end
      tick();
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 10'(i), 32'hA000_0000 + 32'(i), 4'hF);
         tick();
      end
      rsp_ready_i = 1'b1;
      for (int c = 0; c < 18; c++) begin
         if (c < 16) drive(1'b1, 1'b0, 10'(c), 32'h0, 4'h0);
         else idle();
         @(negedge clk_i);
         if (c < 16) begin
            checks++;
            if (req_ready_o !== 1'b1) begin failures++; $display("FAIL stream_ready c=%0d: got %b want 1", c, req_ready_o); end
         end
         checks++;
         if (c >= 2) begin
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hA000_0000 + 32'(c - 2)) begin
               failures++;
               $display("FAIL stream_rsp c=%0d: got v=%b d=%h want v=1 d=%h", c, rsp_valid_o, rsp_rdata_o, 32'hA000_0000 + 32'(c - 2));
            end
         end else if (rsp_valid_o !== 1'b0) begin
            failures++; $display("FAIL stream_rsp c=%0d: got v=%b want v=0", c, rsp_valid_o);
         end
         tick();
      end
   endtask

   task automatic test_back_pressure();
      int          bp_v   [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
      int          bp_we  [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      int          bp_a   [12] = '{0, 1, 2, 2, 'h40, 2, 2, 3, 4, 0, 0, 0};
      int          bp_rr  [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
      int          bp_rdy [12] = '{1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
      int          bp_rv  [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      logic [31:0] bp_d   [12] = '{32'h0, 32'h0, 32'hA000_0000, 32'hA000_0000, 32'hA000_0000,
                                   32'hA000_0000, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
                                   32'hA000_0003, 32'hA000_0004, 32'h0};
      for (int c = 0; c < 12; c++) begin
         drive(bp_v[c] != 0, bp_we[c] != 0, 10'(bp_a[c]), 32'h55AA_55AA, 4'hF);
         rsp_ready_i = (bp_rr[c] != 0);
         @(negedge clk_i);
         checks++;
         if (req_ready_o !== (bp_rdy[c] != 0)) begin
            failures++; $display("FAIL bp_ready c=%0d: got %b want %0d", c, req_ready_o, bp_rdy[c]);
         end
         checks++;
         if (rsp_valid_o !== (bp_rv[c] != 0) || rsp_rdata_o !== bp_d[c]) begin
            failures++;
            $display("FAIL bp_rsp c=%0d: got v=%b d=%h want v=%0d d=%h", c, rsp_valid_o, rsp_rdata_o, bp_rv[c], bp_d[c]);
         end
         tick();
      end
      drive(1'b1, 1'b0, 10'h040, 32'h0, 4'h0);
      tick();
      idle();
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h55AA_55AA) begin
         failures++; $display("FAIL bp_write_kept: got v=%b d=%h want v=1 d=55aa55aa", rsp_valid_o, rsp_rdata_o);
      end
      tick();
   endtask

   task automatic test_reset_mid_flight();
      rsp_ready_i = 1'b1;
      drive(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
      tick();
      drive(1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
      tick();
      rst_i = 1'b1;
      drive(1'b1, 1'b0, 10'h030, 32'h0, 4'h0);
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 1'b0 || sram_req_o !== 1'b0) begin
         failures++; $display("FAIL midrst_block: got rdy=%b req=%b want 0/0", req_ready_o, sram_req_o);
      end
      tick();
      rst_i = 1'b0;
      drive(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_late_rsp0: got %b want 0", rsp_valid_o); end
      checks++;
      if (req_ready_o !== 1'b1) begin failures++; $display("FAIL midrst_first_ready: got %b want 1", req_ready_o); end
      tick();
      idle();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_late_rsp1: got %b want 0", rsp_valid_o); end
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL midrst_read: got v=%b d=%h want v=1 d=deadbeef", rsp_valid_o, rsp_rdata_o);
      end
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_tail: got %b want 0", rsp_valid_o); end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] sb_mem [8];
      logic [31:0] e;
      logic [9:0]  a;
      logic        pop, exp_rdy;
      int          size0;
      for (int i = 0; i < 8; i++) begin
         sb_mem[i] = 32'h0101_0101 * 32'(i + 1);
         drive(1'b1, 1'b1, 10'h080 + 10'(i), sb_mem[i], 4'hF);
         tick();
      end
      for (int c = 0; c < 400; c++) begin
         a = 10'h080 + 10'($urandom_range(0, 7));
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, $urandom, 4'($urandom_range(0, 15)));
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         @(negedge clk_i);
         size0 = exp_q.size();
         pop = rsp_valid_o && rsp_ready_i;
         if (pop) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL rand_unexpected c=%0d: got d=%h want no response", c, rsp_rdata_o);
            end else begin
               e = exp_q.pop_front();
               if (rsp_rdata_o !== e) begin
                  failures++; $display("FAIL rand_rdata c=%0d: got %h want %h", c, rsp_rdata_o, e);
               end
            end
         end
         if (req_valid_i) begin
            checks++;
            exp_rdy = req_we_i || (size0 < int'(RspDepth)) || pop;
            if (req_ready_o !== exp_rdy) begin
               failures++; $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready_o, exp_rdy);
            end
            if (req_ready_o) begin
               if (req_we_i) begin
                  for (int b = 0; b < 4; b++)
                     if (req_be_i[b]) sb_mem[req_addr_i[2:0]][b*8 +: 8] = req_wdata_i[b*8 +: 8];
               end else begin
                  exp_q.push_back(sb_mem[req_addr_i[2:0]]);
               end
            end
         end
         tick();
      end
      idle();
      rsp_ready_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         if (rsp_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL drain_unexpected: got d=%h want no response", rsp_rdata_o);
            end else begin
               e = exp_q.pop_front();
               if (rsp_rdata_o !== e) begin
                  failures++; $display("FAIL drain_rdata: got %h want %h", rsp_rdata_o, e);
               end
            end
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL drain_empty: got %0d pending want 0", exp_q.size());
      end
   endtask

   initial begin
      rst_i = 1'b1;
      rsp_ready_i = 1'b0;
      idle();
      test_reset();
      test_write_read();
      test_partial_write();
      test_streaming();
      test_back_pressure();
      test_reset_mid_flight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
